// File: rtl/sync_pulse_arbiter.sv
// sync_pulse_arbiter
// Round-robin arbiter that lets N source-domain requesters share one
// pulse-handshake synchronizer channel (sEN/sRDY). Only one crossing is in
// flight at a time. The owner receives a one-cycle done pulse once the
// synchronizer reports ready again.
//
// Optional feature: define SYNC_ARB_TIMEOUT_EN to add a sticky wait-timeout
// flag (tmo). It is set when a crossing stays in WAIT for 2**TMO_W-1 cycles
// and is cleared by tmo_clr. Without the macro, tmo is tied low and tmo_clr
// is ignored.

module sync_pulse_arbiter #(
    parameter int N     = 4,
    parameter int IDW   = 2,
    parameter int TMO_W = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           hs_en,
    input  logic           hs_rdy,
    output logic           tmo,
    input  logic           tmo_clr
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } stateT;

    stateT          state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winIdx;
    logic           winValid;

    // Scan requests starting at ptr and wrapping. The loop runs from the
    // farthest offset down to zero, so the nearest set bit is the one kept.
    always_comb begin : pickWinner
        logic [IDW:0] cand;
        winValid = 1'b0;
        winIdx   = '0;
        cand     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IDW + 1)'(i);
            if (cand >= (IDW + 1)'(N)) begin
                cand = cand - (IDW + 1)'(N);
            end
            if (req[cand[IDW-1:0]]) begin
                winValid = 1'b1;
                winIdx   = cand[IDW-1:0];
            end
        end
    end

    // Transfer sequencer. Every output is a register, so req and hs_rdy only
    // influence the outputs through state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            done     <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            hs_en    <= 1'b0;
            ptr      <= '0;
        end else begin
            done  <= '0;
            hs_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs_rdy && winValid) begin
                        grant    <= N'(1) << winIdx;
                        grant_id <= winIdx;
                        busy     <= 1'b1;
                        hs_en    <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (hs_rdy) begin
                        done  <= grant;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ptr      <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
                    grant    <= '0;
                    grant_id <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SYNC_ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    logic [TMO_W-1:0] tmoCnt;

    // The wait counter restarts for every crossing. tmo is raised once, on
    // the cycle the counter reaches its maximum; a set in the same cycle
    // overrides a clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmoCnt <= '0;
            tmo    <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                tmoCnt <= '0;
            end else if (state == WAIT && tmoCnt != TMO_MAX) begin
                tmoCnt <= tmoCnt + 1'b1;
            end
            if (state == WAIT && tmoCnt == TMO_MAX - 1'b1) begin
                tmo <= 1'b1;
            end else if (tmo_clr) begin
                tmo <= 1'b0;
            end
        end
    end
`else
    localparam int unusedTmoW = TMO_W;

    logic unusedTmoClr;

    assign unusedTmoClr = tmo_clr;
    assign tmo          = 1'b0;
`endif

endmodule
